serial_alu_seq: RTL and testbench

SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

---
 rtl/serial_alu_seq.sv | 149 ++++++++++++++
 tb/tb_serial_alu_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU: processes operands LSB first through one full-adder slice
// with a registered carry, producing a registered result and zero flag.
module serial_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       sel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] res_o,
    output logic             zero_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Subtract-type ops run A + ~B + 1: inverted B and carry preset to 1.
    function automatic logic is_sub_op(input logic [3:0] sel);
        return (sel == OP_SUB) || (sel == OP_SLT) || (sel == OP_SLTU);
    endfunction

    function automatic logic select_bit(input logic [3:0] sel, input logic a,
                                        input logic b, input logic sum);
        case (sel)
            OP_ADD, OP_SUB: return sum;
            OP_AND:         return a & b;
            OP_OR:          return a | b;
            OP_XOR:         return a ^ b;
            default:        return 1'b0;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-2:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       sel_q, sel_d;

    logic             a_bit, b_raw, b_bit, sum_bit, carry_out;
    logic [WIDTH-1:0] shifted, final_res;

    always_comb begin
        a_bit     = a_q[cnt_q];
        b_raw     = b_q[cnt_q];
        b_bit     = b_raw ^ is_sub_op(sel_q);
        sum_bit   = a_bit ^ b_bit ^ carry_q;
        carry_out = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
        shifted   = {select_bit(sel_q, a_bit, b_raw, sum_bit), shreg_q};

        // On the MSB, carry_q is the carry into the MSB and carry_out the carry out.
        final_res = shifted;
        if (sel_q == OP_SLTU) begin
            final_res    = '0;
            final_res[0] = ~carry_out;
        end else if (sel_q == OP_SLT) begin
            final_res    = '0;
            final_res[0] = sum_bit ^ (carry_q ^ carry_out);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        shreg_d = shreg_q;
        res_d   = res_q;
        zero_d  = zero_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    carry_d = is_sub_op(sel_i);
                    a_d     = a_i;
                    b_d     = b_i;
                    sel_d   = sel_i;
                end
            end
            RUN: begin
                cnt_d   = cnt_q + CNT_W'(1);
                carry_d = carry_out;
                shreg_d = shifted[WIDTH-1:1];
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    res_d   = final_res;
                    zero_d  = (final_res == '0);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            shreg_q <= '0;
            res_q   <= '0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            shreg_q <= shreg_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    // Operand latches are pure data and only matter after an accepted start.
    always_ff @(posedge clk_i) begin
        a_q   <= a_d;
        b_q   <= b_d;
        sel_q <= sel_d;
    end

    assign busy_o = (state_q == RUN);
    assign done_o = (state_q == DONE);
    assign res_o  = res_q;
    assign zero_o = zero_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed self-checking bench for serial_alu_seq at WIDTH=32.
module tb_serial_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   sel = 4'b0000;
    logic         busy, done, zero;
    logic [W-1:0] res;

    int pass_cnt = 0;
    int total    = 0;

    serial_alu_seq #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b),
        .sel_i(sel), .busy_o(busy), .done_o(done), .res_o(res), .zero_o(zero)
    );

    always #5 clk = ~clk;

    // Called just after a negedge; the request is accepted on the next posedge.
    task automatic issue(input logic [3:0] s, input logic [W-1:0] av, input logic [W-1:0] bv);
        start = 1'b1; sel = s; a = av; b = bv;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts negedges until done_o; flags busy gaps, busy/done overlap and early res changes.
    task automatic wait_done(input logic [W-1:0] prev, output int cyc, output bit ok,
                             output bit bad, output bit res_moved);
        cyc = 0; ok = 1'b0; bad = 1'b0; res_moved = 1'b0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (busy && done) bad = 1'b1;
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (!busy) bad = 1'b1;
            if (res !== prev) res_moved = 1'b1;
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] s, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] exp_res);
        int cyc; bit ok, bad, moved;
        logic [W-1:0] prev;
        prev = res;
        issue(s, av, bv);
        wait_done(prev, cyc, ok, bad, moved);
        total++;
        if (!ok || cyc !== W + 1 || bad || moved)
            $display("FAIL %s timing: cycles=%0d done_seen=%0b bad=%0b res_moved=%0b, required cycles=%0d clean",
                     name, cyc, ok, bad, moved, W + 1);
        else pass_cnt++;
        total++;
        if (res !== exp_res || zero !== (exp_res == '0))
            $display("FAIL %s result: res=%h zero=%0b, required res=%h zero=%0b",
                     name, res, zero, exp_res, (exp_res == '0));
        else pass_cnt++;
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || res !== '0 || zero !== 1'b1)
            $display("FAIL reset_state: busy=%0b done=%0b res=%h zero=%0b, required 0 0 0 1",
                     busy, done, res, zero);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_add;
        @(negedge clk);
        run_op("add_5_7", 4'b0000, 32'd5, 32'd7, 32'h0000000C);
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL done_one_cycle: done=%0b busy=%0b, required 0 0", done, busy);
        else pass_cnt++;
        run_op("add_wrap", 4'b0000, 32'hFFFFFFFF, 32'h00000002, 32'h00000001);
    endtask

    task automatic test_sub;
        @(negedge clk);
        run_op("sub_3_5", 4'b0101, 32'd3, 32'd5, 32'hFFFFFFFE);
        @(negedge clk);
        run_op("sub_9_9", 4'b0101, 32'd9, 32'd9, 32'h00000000);
    endtask

    task automatic test_compare;
        @(negedge clk);
        run_op("slt_m1_1", 4'b0110, 32'hFFFFFFFF, 32'd1, 32'd1);
        @(negedge clk);
        run_op("sltu_max_1", 4'b0100, 32'hFFFFFFFF, 32'd1, 32'd0);
        @(negedge clk);
        run_op("slt_ovf", 4'b0110, 32'h7FFFFFFF, 32'h80000000, 32'd0);
        @(negedge clk);
        run_op("sltu_1_2", 4'b0100, 32'd1, 32'd2, 32'd1);
        @(negedge clk);
        run_op("slt_eq", 4'b0110, 32'd4, 32'd4, 32'd0);
    endtask

    task automatic test_logic;
        @(negedge clk);
        run_op("xor", 4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0);
        @(negedge clk);
        run_op("and", 4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
        @(negedge clk);
        run_op("or", 4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0);
    endtask

    task automatic test_invalid_sel;
        @(negedge clk);
        run_op("sel_1111", 4'b1111, 32'hFFFFFFFF, 32'h12345678, 32'd0);
        @(negedge clk);
        run_op("sel_0111", 4'b0111, 32'hDEADBEEF, 32'h1, 32'd0);
    endtask

    task automatic test_ignore_start;
        int cyc; bit ok, bad, moved;
        logic [W-1:0] prev;
        @(negedge clk);
        prev = res;
        issue(4'b0011, 32'h12345678, 32'h0F0F0F0F);
        repeat (5) @(negedge clk);
        start = 1'b1; sel = 4'b0000; a = 32'hFFFFFFFF; b = 32'h0;
        @(negedge clk);
        start = 1'b0;
        wait_done(prev, cyc, ok, bad, moved);
        total++;
        if (!ok || cyc !== W + 1 - 6 || bad)
            $display("FAIL ignore_start timing: cycles=%0d done_seen=%0b bad=%0b, required cycles=%0d",
                     cyc, ok, bad, W + 1 - 6);
        else pass_cnt++;
        total++;
        if (res !== 32'h1D3B5977)
            $display("FAIL ignore_start result: res=%h, required 1d3b5977", res);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int cyc; bit ok, bad, moved;
        logic [W-1:0] prev;
        @(negedge clk);
        prev = res;
        start = 1'b1; sel = 4'b0000; a = 32'h80000000; b = 32'h80000000;
        wait_done(prev, cyc, ok, bad, moved);
        total++;
        if (!ok || res !== 32'h0 || zero !== 1'b1)
            $display("FAIL b2b_first: done_seen=%0b res=%h zero=%0b, required 1 00000000 1",
                     ok, res, zero);
        else pass_cnt++;
        sel = 4'b0101; a = 32'd10; b = 32'd3;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL b2b_idle_gap: busy=%0b done=%0b, required 0 0", busy, done);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (busy !== 1'b1)
            $display("FAIL b2b_accept: busy=%0b, required 1", busy);
        else pass_cnt++;
        start = 1'b0;
        wait_done(32'h0, cyc, ok, bad, moved);
        total++;
        if (!ok || cyc !== W || bad || res !== 32'd7)
            $display("FAIL b2b_second: cycles=%0d done_seen=%0b bad=%0b res=%h, required cycles=%0d res=00000007",
                     cyc, ok, bad, res, W);
        else pass_cnt++;
    endtask

    task automatic test_midrun_reset;
        bit saw_done;
        @(negedge clk);
        issue(4'b0000, 32'h00000100, 32'h00000200);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || res !== '0 || zero !== 1'b1)
            $display("FAIL midrun_reset_state: busy=%0b done=%0b res=%h zero=%0b, required 0 0 0 1",
                     busy, done, res, zero);
        else pass_cnt++;
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        total++;
        if (saw_done !== 1'b0)
            $display("FAIL midrun_no_done: done pulse seen=%0b, required 0", saw_done);
        else pass_cnt++;
        // Release on a negedge and request immediately: accepted on the next posedge.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_op("add_after_reset", 4'b0000, 32'd1, 32'd1, 32'd2);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_compare();
        test_logic();
        test_invalid_sel();
        test_ignore_start();
        test_back_to_back();
        test_midrun_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
